// File: rtl/cfg_reg_responder.sv
// rtl/cfg_reg_responder.sv - config-register responder driving the data IP's active width
//
// Purpose: single-outstanding request/response register slave holding a shadow
// DATA_WIDTH. The active width presented to the IP changes only after a commit,
// and only on a cycle where the IP reports core_idle.
//
// Optional feature macro: CFG_REG_LOCK_EN (sticky CTRL bit2 lock that blocks
// WIDTH writes and commits until reset).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write, req_addr,  request type, byte address, write data
//   req_wdata
//   rsp_valid/rsp_ready   response handshake, response held until taken
//   rsp_rdata, rsp_err    read data (0 for writes/errors), access error
//   core_idle             IP has no transfer in flight
//   cfg_data_width        active width to the IP
//   cfg_update            one-cycle pulse when the active width is (re)loaded

module cfg_reg_responder #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DEF_DATA_WIDTH = 32,
  parameter int unsigned MAX_DATA_WIDTH = 64,
  parameter logic [31:0] ID_VALUE       = 32'h5643_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              core_idle,
  output logic [7:0]        cfg_data_width,
  output logic              cfg_update
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam logic [1:0] SEL_CTRL  = 2'd0;
  localparam logic [1:0] SEL_WIDTH = 2'd1;
  localparam logic [1:0] SEL_STAT  = 2'd2;
  localparam logic [1:0] SEL_ID    = 2'd3;

  localparam logic [7:0] DEF_W = 8'(DEF_DATA_WIDTH);

  state_t      state_q, state_d;
  logic        enable_q;
  logic        pending_q;
  logic [7:0]  shadow_q;
  logic        lock_q;

  logic        accept;
  logic [31:0] addr_ext;
  logic [1:0]  sel;
  logic        width_illegal;
  logic        lock_err;
  logic        err_d;
  logic [31:0] rdata_d;
  logic        wr_ctrl;
  logic        wr_width;
  logic        commit_set;
  logic        apply;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ decode
  assign accept   = req_valid && req_ready;
  assign addr_ext = 32'(req_addr);
  assign sel      = addr_ext[3:2];

  // Legal width: 8..MAX in steps of 8, nothing above bit 7.
  assign width_illegal = (req_wdata[31:8] != 24'd0) || (req_wdata[7:0] == 8'd0) ||
                         (req_wdata[2:0] != 3'd0) || (req_wdata > MAX_DATA_WIDTH);

  always_comb begin
    lock_err = 1'b0;
    if (lock_q && req_write) begin
      if (sel == SEL_WIDTH) lock_err = 1'b1;
      if ((sel == SEL_CTRL) && req_wdata[1]) lock_err = 1'b1;
    end
  end

  always_comb begin
    err_d   = 1'b0;
    rdata_d = 32'd0;
    if ((addr_ext[1:0] != 2'd0) || (addr_ext > 32'hC)) begin
      err_d = 1'b1;
    end else if (req_write) begin
      if ((sel == SEL_STAT) || (sel == SEL_ID)) err_d = 1'b1;
      if ((sel == SEL_WIDTH) && width_illegal)  err_d = 1'b1;
      if (lock_err)                              err_d = 1'b1;
    end else begin
      case (sel)
        SEL_CTRL:  rdata_d = {29'd0, lock_q, 1'b0, enable_q};
        SEL_WIDTH: rdata_d = {24'd0, shadow_q};
        SEL_STAT:  rdata_d = {16'd0, cfg_data_width, 6'd0, core_idle, pending_q};
        SEL_ID:    rdata_d = ID_VALUE;
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  assign wr_ctrl  = accept && req_write && !err_d && (sel == SEL_CTRL);
  assign wr_width = accept && req_write && !err_d && (sel == SEL_WIDTH);

  // Commit counts when enable is being written to 1 or is already set.
  assign commit_set = wr_ctrl && req_wdata[1] && (req_wdata[0] || enable_q);
  assign apply      = pending_q && core_idle;

  // ------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end
  end

  // The apply reads shadow_q before any same-cycle WIDTH write lands, and a
  // same-cycle commit re-arms pending for the newer shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q       <= 1'b0;
      pending_q      <= 1'b0;
      shadow_q       <= DEF_W;
      cfg_data_width <= DEF_W;
      cfg_update     <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      if (wr_ctrl)  enable_q <= req_wdata[0];
      if (wr_width) shadow_q <= req_wdata[7:0];
      if (apply) begin
        cfg_data_width <= shadow_q;
        cfg_update     <= 1'b1;
      end
      if (commit_set) pending_q <= 1'b1;
      else if (apply) pending_q <= 1'b0;
    end
  end

`ifdef CFG_REG_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      lock_q <= 1'b0;
    else if (wr_ctrl && req_wdata[2]) lock_q <= 1'b1;
  end
`else
  assign lock_q = 1'b0;
`endif

endmodule
